ula_sequencer: RTL

// Multi-cycle control FSM that sequences the shared ULA, memory port, PC and register file of the
// RV32I core. Decodes opcode per instruction, emits ula_op (consumed by ula_control with

---
 rtl/ula_sequencer_if.sv | 21 ++
 rtl/ula_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ula_sequencer_if.sv
// rtl/ula_sequencer_if.sv - memory request/ready handshake between the sequencer and the memory port
interface ula_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/ula_sequencer.sv
// rtl/ula_sequencer.sv - multi-cycle RV32I control FSM driving ULA, memory port, PC and register file
module ula_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              opcode,
  input  logic                    branch_taken,
  input  logic                    halt_clr,
  ula_sequencer_if.master         mem,
  output logic                    pc_write,
  output logic                    ir_write,
  output logic [2:0]              ula_op,
  output logic [1:0]              ula_src_a,
  output logic [1:0]              ula_src_b,
  output logic                    pc_src,
  output logic                    reg_write,
  output logic [1:0]              wb_sel,
  output logic                    trap,
  output logic [3:0]              state
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_EXEC_U   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_JALR     = 4'd13,
    S_TRAP     = 4'd14,
    S_UNUSED   = 4'd15
  } state_t;

  // Timeout fires on the MEM_WAIT_MAX-th consecutive unanswered request cycle.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt;
  logic       in_mem;
  logic       timeout;
  logic       mem_req_c;
  logic       mem_we_c;
  logic       addr_sel_c;

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout = in_mem && !mem.mem_ready && (wait_cnt >= WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Any state change clears the counter, so each memory state starts a fresh wait window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (state_d != state_q) begin
      wait_cnt <= 8'd0;
    end else if (in_mem && !mem.mem_ready && (wait_cnt != 8'hff)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel_c = 1'b0;
    ula_op     = 3'b000;
    ula_src_a  = 2'd0;
    ula_src_b  = 2'd0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 2'd0;
    trap       = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_c = 1'b1;
        ula_src_a = 2'd1;
        ula_src_b = 2'd2;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        ula_src_a = 2'd2;
        ula_src_b = 2'd1;
        case (opcode)
          7'b0110011:             state_d = S_EXEC_R;
          7'b0010011:             state_d = S_EXEC_I;
          7'b0110111, 7'b0010111: state_d = S_EXEC_U;
          7'b0000011, 7'b0100011: state_d = S_MEM_ADDR;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          default:                state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        ula_op  = 3'b010;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        ula_op    = 3'b011;
        ula_src_b = 2'd1;
        state_d   = S_WB_ALU;
      end
      S_EXEC_U: begin
        ula_op    = opcode[5] ? 3'b100 : 3'b101;
        ula_src_a = 2'd2;
        ula_src_b = 2'd1;
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        ula_src_b = 2'd1;
        state_d   = opcode[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        if (mem.mem_ready)  state_d = S_WB_MEM;
        else if (timeout)   state_d = S_TRAP;
      end
      S_MEM_WR: begin
        mem_req_c  = 1'b1;
        mem_we_c   = 1'b1;
        addr_sel_c = 1'b1;
        if (mem.mem_ready)  state_d = S_FETCH;
        else if (timeout)   state_d = S_TRAP;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'd1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ula_op   = 3'b001;
        pc_src   = 1'b1;
        pc_write = branch_taken;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        state_d   = S_FETCH;
      end
      S_JALR: begin
        ula_src_b = 2'd1;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
        if (halt_clr) state_d = S_RST;
      end
      default: state_d = S_RST;
    endcase
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_we   = mem_we_c;
  assign mem.addr_sel = addr_sel_c;
  assign state        = state_q;

endmodule
